// File: rtl/pacman_pkg.sv
// pacman_pkg -- constants and types shared by the Pac-Man pellet logic.
//
// Holds the playfield geometry (tile size, grid dimensions), the BCD score
// increment for one pellet, the in-tile pellet dot window and the tracker
// state enumeration.
package pacman_pkg;

  // Tile edge is 1 << TILE_SHIFT pixels.
  localparam int TILE_SHIFT = 5;
  localparam int COLS       = 20;
  localparam int ROWS       = 15;

  // Points per pellet, already BCD-encoded.
  localparam logic [15:0] PELLET_PTS = 16'h0010;

  // In-tile pixel offsets that form the visible 4x4 pellet dot.
  localparam int DOT_LO = 14;
  localparam int DOT_HI = 17;

  // Largest score the four BCD digits can show.
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // PLAY: pellets can be eaten. CLEAR: board empty, everything frozen.
  typedef enum logic {
    PLAY  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_add4.sv
// bcd_add4 -- four-digit packed-BCD adder with saturation.
//
// Ports:
//   a    in  16  augend, 4 packed BCD digits (digit 0 in bits [3:0])
//   b    in  16  addend, 4 packed BCD digits
//   sum  out 16  a + b in BCD; 16'h9999 when the true sum exceeds 9999
//
// Purely combinational; a ripple of per-digit decimal carries. Inputs are
// assumed to hold valid BCD digits (0..9 each).
module bcd_add4
  import pacman_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [4:0]  carry;
  logic [15:0] digits;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [4:0] raw;

    // Binary sum of two digits plus carry-in is at most 19, so 5 bits hold it.
    assign raw = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]} + {4'd0, carry[gi]};

    // Anything past 9 wraps to the next decade and carries upward.
    assign carry[gi+1]       = (raw > 5'd9);
    assign digits[4*gi +: 4] = carry[gi+1] ? 4'(raw - 5'd10) : raw[3:0];
  end

  // A carry out of the thousands digit means the result passed 9999.
  assign sum = carry[4] ? SCORE_MAX : digits;

endmodule

// File: rtl/pellet_tracker.sv
// pellet_tracker -- keeps the live-pellet map, score and pellet count.
//
// Ports:
//   frame_clk    in   1  one rising edge per video frame
//   Reset        in   1  asynchronous active-high reset (refills the board)
//   BallX/BallY  in  10  Pac-Man centre position in pixels
//   DrawX/DrawY  in  10  renderer pixel being queried
//   pellet_on    out  1  query pixel is on a live pellet dot (combinational)
//   eaten        out  1  one-frame pulse when a pellet is consumed
//   score        out 16  4-digit BCD score, saturating at 9999
//   remaining    out  9  count of live pellets
//   level_clear  out  1  every pellet has been eaten
//
// Two-stage pipeline. Stage 1 registers the tile under Pac-Man and whether
// that tile is on the board. Stage 2 looks the tile up in the bitmap and, if
// the pellet is still there, consumes it: bit cleared, eaten pulsed, score
// and count updated together on one edge. Eating the last pellet moves the
// tracker to CLEAR, where all state is frozen until Reset.
module pellet_tracker #(
  parameter int          TILE_SHIFT = pacman_pkg::TILE_SHIFT,
  parameter int          COLS       = pacman_pkg::COLS,
  parameter int          ROWS       = pacman_pkg::ROWS,
  parameter logic [15:0] PELLET_PTS = pacman_pkg::PELLET_PTS
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        pellet_on,
  output logic        eaten,
  output logic [15:0] score,
  output logic [8:0]  remaining,
  output logic        level_clear
);

  import pacman_pkg::*;

  localparam int NUM_TILES = COLS * ROWS;
  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int IDX_W     = $clog2(NUM_TILES);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0]     col_q,       col_d;
  logic [ROW_W-1:0]     row_q,       row_d;
  logic                 valid_q,     valid_d;
  logic [NUM_TILES-1:0] bitmap_q,    bitmap_d;
  logic [15:0]          score_q,     score_d;
  logic [8:0]           remaining_q, remaining_d;
  logic                 eaten_q,     eaten_d;
  state_e               state_q,     state_d;

  // ---------------------------------------------------------------------------
  // Stage 1: tile under Pac-Man
  // ---------------------------------------------------------------------------
  logic [9:0] ball_col;
  logic [9:0] ball_row;

  assign ball_col = BallX >> TILE_SHIFT;
  assign ball_row = BallY >> TILE_SHIFT;

  // Range is judged on the full-width tile number; only in-range values are
  // narrowed for indexing, so a far-off position can never alias a tile.
  assign valid_d = (ball_col < 10'(COLS)) && (ball_row < 10'(ROWS));
  assign col_d   = ball_col[COL_W-1:0];
  assign row_d   = ball_row[ROW_W-1:0];

  // ---------------------------------------------------------------------------
  // Stage 2: look up and consume
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] hit_idx;
  logic             hit;
  logic [15:0]      score_sum;

  assign hit_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);

  // Only a live pellet on an on-board tile while still playing counts.
  assign hit = (state_q == PLAY) && valid_q && bitmap_q[hit_idx];

  bcd_add4 u_bcd_add4 (
    .a   (score_q),
    .b   (PELLET_PTS),
    .sum (score_sum)
  );

  always_comb begin
    bitmap_d    = bitmap_q;
    score_d     = score_q;
    remaining_d = remaining_q;
    eaten_d     = 1'b0;
    state_d     = state_q;

    if (hit) begin
      bitmap_d[hit_idx] = 1'b0;
      eaten_d           = 1'b1;
      score_d           = score_sum;
      remaining_d       = remaining_q - 9'd1;
      // This edge takes the count to zero: the board is cleared.
      if (remaining_q == 9'd1) begin
        state_d = CLEAR;
      end
    end
  end

  // Reset also drops any stage-1 sample in flight, so nothing is eaten for
  // a position captured just before Reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      col_q       <= '0;
      row_q       <= '0;
      valid_q     <= 1'b0;
      bitmap_q    <= '1;
      score_q     <= '0;
      remaining_q <= 9'(NUM_TILES);
      eaten_q     <= 1'b0;
      state_q     <= PLAY;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      valid_q     <= valid_d;
      bitmap_q    <= bitmap_d;
      score_q     <= score_d;
      remaining_q <= remaining_d;
      eaten_q     <= eaten_d;
      state_q     <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Renderer query: 4x4 dot in the middle of each live tile
  // ---------------------------------------------------------------------------
  logic [9:0]            draw_col;
  logic [9:0]            draw_row;
  logic                  draw_in_range;
  logic [IDX_W-1:0]      draw_idx;
  logic [TILE_SHIFT-1:0] off_x;
  logic [TILE_SHIFT-1:0] off_y;
  logic                  dot_x;
  logic                  dot_y;

  assign draw_col      = DrawX >> TILE_SHIFT;
  assign draw_row      = DrawY >> TILE_SHIFT;
  assign draw_in_range = (draw_col < 10'(COLS)) && (draw_row < 10'(ROWS));

  // Park the index at 0 off-board so the bitmap read stays inside the vector.
  assign draw_idx = draw_in_range
                  ? IDX_W'(draw_row[ROW_W-1:0]) * IDX_W'(COLS) + IDX_W'(draw_col[COL_W-1:0])
                  : '0;

  assign off_x = DrawX[TILE_SHIFT-1:0];
  assign off_y = DrawY[TILE_SHIFT-1:0];
  assign dot_x = (off_x >= TILE_SHIFT'(DOT_LO)) && (off_x <= TILE_SHIFT'(DOT_HI));
  assign dot_y = (off_y >= TILE_SHIFT'(DOT_LO)) && (off_y <= TILE_SHIFT'(DOT_HI));

  assign pellet_on = draw_in_range && dot_x && dot_y && bitmap_q[draw_idx];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign eaten       = eaten_q;
  assign score       = score_q;
  assign remaining   = remaining_q;
  assign level_clear = (state_q == CLEAR);

endmodule

// File: tb/tb_pellet_tracker.sv
// Bench for pellet_tracker: directed scenarios plus random movement, all
// checked against a tile-array / decimal-score model. A second instance with
// a large per-pellet value exercises score saturation.
module tb_pellet_tracker;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [9:0]  BallX = '0, BallY = '0, DrawX = '0, DrawY = '0;
  logic        pellet_on, eaten, level_clear;
  logic [15:0] score;
  logic [8:0]  remaining;
  logic        pellet_on2, eaten2, level_clear2;
  logic [15:0] score2;
  logic [8:0]  remaining2;

  always #5 frame_clk = ~frame_clk;

  pellet_tracker dut (
    .frame_clk(frame_clk), .Reset(Reset), .BallX(BallX), .BallY(BallY),
    .DrawX(DrawX), .DrawY(DrawY), .pellet_on(pellet_on), .eaten(eaten),
    .score(score), .remaining(remaining), .level_clear(level_clear)
  );

  pellet_tracker #(.PELLET_PTS(16'h4000)) dut_big (
    .frame_clk(frame_clk), .Reset(Reset), .BallX(BallX), .BallY(BallY),
    .DrawX(DrawX), .DrawY(DrawY), .pellet_on(pellet_on2), .eaten(eaten2),
    .score(score2), .remaining(remaining2), .level_clear(level_clear2)
  );

  // ---------------- reference model ----------------
  bit pel [15][20];      // pellet present at [row][col]
  int rem_m;
  int score_m;           // decimal score, pellet worth 10
  int score2_m;          // decimal score, pellet worth 4000
  bit clr_m;
  bit eaten_m;
  // Position sampled one frame ago, waiting to be acted on.
  bit pend_ok;
  int pend_r, pend_c;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;
  int n_eat    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (step %0d)", tag, got, exp, n_step);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit model_pellet_on(input int dx, input int dy);
    int tc, tr, ox, oy;
    tc = dx / 32; tr = dy / 32; ox = dx % 32; oy = dy % 32;
    if (tc >= 20 || tr >= 15) return 1'b0;
    if (ox < 14 || ox > 17 || oy < 14 || oy > 17) return 1'b0;
    return pel[tr][tc];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) pel[r][c] = 1'b1;
    rem_m = 300; score_m = 0; score2_m = 0; clr_m = 1'b0;
    eaten_m = 1'b0; pend_ok = 1'b0;
  endtask

  // What one frame edge does, given the position presented at it.
  task automatic model_edge(input int x, input int y);
    eaten_m = 1'b0;
    if (!clr_m && pend_ok && pel[pend_r][pend_c]) begin
      pel[pend_r][pend_c] = 1'b0;
      eaten_m  = 1'b1;
      rem_m    = rem_m - 1;
      score_m  = (score_m + 10 > 9999) ? 9999 : score_m + 10;
      score2_m = (score2_m + 4000 > 9999) ? 9999 : score2_m + 4000;
      if (rem_m == 0) clr_m = 1'b1;
    end
    pend_c  = x / 32;
    pend_r  = y / 32;
    pend_ok = (pend_c < 20) && (pend_r < 15);
  endtask

  task automatic check_all();
    check("eaten",       eaten,       eaten_m);
    check("score",       score,       to_bcd(score_m));
    check("remaining",   remaining,   rem_m);
    check("level_clear", level_clear, clr_m);
    check("pellet_on",   pellet_on,   model_pellet_on(DrawX, DrawY));
    check("eaten_big",   eaten2,      eaten_m);
    check("score_big",   score2,      to_bcd(score2_m));
  endtask

  // One frame: present a position and a random query pixel, clock, check.
  task automatic step(input int x, input int y);
    int tc, tr;
    tc = $urandom_range(0, 21);
    tr = $urandom_range(0, 16);
    BallX = 10'(x);
    BallY = 10'(y);
    DrawX = 10'(tc * 32 + $urandom_range(10, 21));
    DrawY = 10'(tr * 32 + $urandom_range(10, 21));
    @(posedge frame_clk);
    model_edge(x, y);
    n_step++;
    #1;
    check_all();
    if (eaten_m) n_eat++;
    $display("step %0d ball=(%0d,%0d) eaten=%0b score=%h rem=%0d clear=%0b",
             n_step, x, y, eaten, score, remaining, level_clear);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    check("rst_eaten",     eaten,       1'b0);
    check("rst_score",     score,       16'h0000);
    check("rst_remaining", remaining,   9'd300);
    check("rst_clear",     level_clear, 1'b0);
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic probe(input string tag, input int dx, input int dy, input bit exp);
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    #1;
    check(tag, pellet_on, exp);
    $display("probe %s draw=(%0d,%0d) pellet_on=%0b", tag, dx, dy, pellet_on);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Query pixels on a fresh board.
    probe("dot_centre", 335, 335, 1'b1);
    probe("dot_offset", 330, 335, 1'b0);

    // Park on tile (row 10, col 10): one pulse, then nothing more.
    n_eat = 0;
    for (int i = 0; i < 12; i++) step(320, 350);
    check("tile_eat_count", n_eat, 1);
    check("tile_score",     score, 16'h0010);
    check("tile_remaining", remaining, 9'd299);
    probe("dot_eaten", 335, 335, 1'b0);

    // Off the right edge of the board.
    for (int i = 0; i < 4; i++) step(700, 100);
    check("offboard_score", score, 16'h0010);

    // Reset lands while a live tile sample is in flight.
    step(48, 48);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    check("midrst_eaten", eaten, 1'b0);
    @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) step(700, 700);
    check("midrst_score",     score,     16'h0000);
    check("midrst_remaining", remaining, 9'd300);
    probe("midrst_dot", 48, 48, 1'b1);

    // Random wandering, partly off-board.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 719), $urandom_range(0, 543));

    // Sweep every tile to clear the board.
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++)
        step(c * 32 + $urandom_range(0, 31), r * 32 + $urandom_range(0, 31));
    step(1000, 1000);
    step(1000, 1000);
    check("clear_flag",      level_clear, 1'b1);
    check("clear_remaining", remaining,   9'd0);
    check("clear_score",     score,       16'h3000);
    check("sat_score",       score2,      16'h9999);

    // Board stays frozen after clearing.
    for (int i = 0; i < 8; i++)
      step($urandom_range(0, 639), $urandom_range(0, 479));
    check("frozen_score", score, 16'h3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
